// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions for the instruction fetch path: FSM state encoding,
// PC step and address alignment helper.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_DROP = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_e;

   localparam logic [31:0] PC_INC = 32'd4;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'd3;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: branch redirect, instruction-memory read port and
// decode handoff. The master side is the fetch unit itself.
interface fetch_unit_if;
   logic        i_FetchUnit_redirect;
   logic [31:0] i_FetchUnit_redirectPc;
   logic        o_FetchUnit_memReq;
   logic [31:0] o_FetchUnit_memAddr;
   logic        i_FetchUnit_memAck;
   logic [31:0] i_FetchUnit_memData;
   logic        o_FetchUnit_valid;
   logic [31:0] o_FetchUnit_instr;
   logic [31:0] o_FetchUnit_pc;
   logic        i_FetchUnit_ready;

   modport master (
      input  i_FetchUnit_redirect, i_FetchUnit_redirectPc,
      input  i_FetchUnit_memAck, i_FetchUnit_memData, i_FetchUnit_ready,
      output o_FetchUnit_memReq, o_FetchUnit_memAddr,
      output o_FetchUnit_valid, o_FetchUnit_instr, o_FetchUnit_pc
   );

   modport slave (
      output i_FetchUnit_redirect, i_FetchUnit_redirectPc,
      output i_FetchUnit_memAck, i_FetchUnit_memData, i_FetchUnit_ready,
      input  o_FetchUnit_memReq, o_FetchUnit_memAddr,
      input  o_FetchUnit_valid, o_FetchUnit_instr, o_FetchUnit_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Single-entry instruction fetch unit: issues one word-aligned read at a time,
// buffers the result for decode and handles branch redirects mid-request.
import fetch_unit_pkg::*;

module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   fetch_unit_if.master  fu
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  pending_q, pending_d;
   logic         valid_q, valid_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  out_pc_q, out_pc_d;
   logic         mem_req_q, mem_req_d;

   logic         ack_eff;
   logic [31:0]  redir_pc;

   // An ack only counts against a request that is actually on the bus.
   assign ack_eff  = fu.i_FetchUnit_memAck && mem_req_q;
   assign redir_pc = word_align(fu.i_FetchUnit_redirectPc);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pending_d = pending_q;
      valid_d   = valid_q;
      instr_d   = instr_q;
      out_pc_d  = out_pc_q;
      unique case (state_q)
         ST_REQ: begin
            if (ack_eff) begin
               if (fu.i_FetchUnit_redirect) begin
                  pc_d = redir_pc;
               end else begin
                  instr_d  = fu.i_FetchUnit_memData;
                  out_pc_d = pc_q;
                  pc_d     = pc_q + PC_INC;
                  valid_d  = 1'b1;
                  state_d  = ST_HOLD;
               end
            end else if (fu.i_FetchUnit_redirect) begin
               // Nothing on the bus yet (first cycle after reset): retarget directly.
               if (mem_req_q) begin
                  pending_d = redir_pc;
                  state_d   = ST_DROP;
               end else begin
                  pc_d = redir_pc;
               end
            end
         end
         ST_DROP: begin
            if (ack_eff) begin
               pc_d    = fu.i_FetchUnit_redirect ? redir_pc : pending_q;
               state_d = ST_REQ;
            end else if (fu.i_FetchUnit_redirect) begin
               pending_d = redir_pc;
            end
         end
         ST_HOLD: begin
            if (fu.i_FetchUnit_redirect) begin
               valid_d = 1'b0;
               pc_d    = redir_pc;
               state_d = ST_REQ;
            end else if (fu.i_FetchUnit_ready) begin
               valid_d = 1'b0;
               state_d = ST_REQ;
            end
         end
         default: begin
            state_d = ST_REQ;
         end
      endcase
      mem_req_d = (state_d != ST_HOLD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_REQ;
         pc_q      <= word_align(RESET_PC);
         pending_q <= 32'd0;
         valid_q   <= 1'b0;
         instr_q   <= 32'd0;
         out_pc_q  <= 32'd0;
         mem_req_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pending_q <= pending_d;
         valid_q   <= valid_d;
         instr_q   <= instr_d;
         out_pc_q  <= out_pc_d;
         mem_req_q <= mem_req_d;
      end
   end

   assign fu.o_FetchUnit_memReq  = mem_req_q;
   assign fu.o_FetchUnit_memAddr = pc_q;
   assign fu.o_FetchUnit_valid   = valid_q;
   assign fu.o_FetchUnit_instr   = instr_q;
   assign fu.o_FetchUnit_pc      = out_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios plus a randomized run of fetch_unit against a
// stream-level model of which addresses must be fetched and delivered.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_3000;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   fetch_unit_if bus();

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fu    (bus)
   );

   always #5 clk = ~clk;

   // Memory contents are a fixed function of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic redir, input logic [31:0] tgt, input logic ack,
                        input logic [31:0] data, input logic rdy);
      bus.i_FetchUnit_redirect   = redir;
      bus.i_FetchUnit_redirectPc = tgt;
      bus.i_FetchUnit_memAck     = ack;
      bus.i_FetchUnit_memData    = data;
      bus.i_FetchUnit_ready      = rdy;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      #1;
      chk("rst_memReq", bus.o_FetchUnit_memReq, 32'd0);
      chk("rst_valid",  bus.o_FetchUnit_valid,  32'd0);
      chk("rst_instr",  bus.o_FetchUnit_instr,  32'd0);
      chk("rst_pc",     bus.o_FetchUnit_pc,     32'd0);
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   logic        prev_req, prev_ack, prev_valid, prev_ready, prev_redir;
   logic [31:0] prev_addr, prev_pc, prev_instr, prev_tgt;
   logic [31:0] exp_next, req_addr, t, d;
   logic        taint, new_req, a, r, rd;
   int          wait_cnt, cnt;

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);

      // Reset release, first fetch and latency to the next request.
      do_reset();
      tick();
      chk("first_memReq", bus.o_FetchUnit_memReq, 32'd1);
      chk("first_addr",   bus.o_FetchUnit_memAddr, RST_PC);
      drive(1'b0, 32'd0, 1'b1, mem_word(RST_PC), 1'b1);
      tick();
      chk("first_valid",  bus.o_FetchUnit_valid, 32'd1);
      chk("first_pc",     bus.o_FetchUnit_pc, RST_PC);
      chk("first_instr",  bus.o_FetchUnit_instr, mem_word(RST_PC));
      chk("first_hold_noreq", bus.o_FetchUnit_memReq, 32'd0);
      drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      tick();
      chk("second_memReq", bus.o_FetchUnit_memReq, 32'd1);
      chk("second_addr",   bus.o_FetchUnit_memAddr, RST_PC + 32'd4);

      // Zero-wait memory, ready held high: one instruction every 2 cycles.
      do_reset();
      cnt = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (bus.o_FetchUnit_valid) begin
            chk("stream_pc", bus.o_FetchUnit_pc, RST_PC + 32'(4 * cnt));
            chk("stream_cycle", 32'(c), 32'(2 * cnt + 1));
            cnt++;
         end
         drive(1'b0, 32'd0, bus.o_FetchUnit_memReq, mem_word(bus.o_FetchUnit_memAddr), 1'b1);
      end
      chk("stream_count", 32'(cnt), 32'd4);

      // Redirect while the request is outstanding, ack three cycles later.
      do_reset();
      tick();
      drive(1'b1, 32'h0000_4000, 1'b0, 32'd0, 1'b1);
      for (int c = 0; c < 3; c++) begin
         tick();
         drive(1'b0, 32'd0, (c == 2), mem_word(RST_PC), 1'b1);
         chk("drop_addr_stable", bus.o_FetchUnit_memAddr, RST_PC);
         chk("drop_memReq", bus.o_FetchUnit_memReq, 32'd1);
         chk("drop_no_valid", bus.o_FetchUnit_valid, 32'd0);
      end
      tick();
      chk("drop_new_addr", bus.o_FetchUnit_memAddr, 32'h0000_4000);
      chk("drop_new_req",  bus.o_FetchUnit_memReq, 32'd1);
      chk("drop_no_valid_after", bus.o_FetchUnit_valid, 32'd0);

      // Hold for 5 cycles with stray acks, then redirect beats ready.
      drive(1'b0, 32'd0, 1'b1, mem_word(32'h0000_4000), 1'b0);
      tick();
      chk("hold_valid", bus.o_FetchUnit_valid, 32'd1);
      chk("hold_pc",    bus.o_FetchUnit_pc, 32'h0000_4000);
      for (int c = 0; c < 5; c++) begin
         drive(1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);
         tick();
         chk("hold_stable_valid", bus.o_FetchUnit_valid, 32'd1);
         chk("hold_stable_pc",    bus.o_FetchUnit_pc, 32'h0000_4000);
         chk("hold_stable_instr", bus.o_FetchUnit_instr, mem_word(32'h0000_4000));
         chk("hold_no_req",       bus.o_FetchUnit_memReq, 32'd0);
      end
      drive(1'b1, 32'h0000_5000, 1'b0, 32'd0, 1'b1);
      tick();
      chk("hold_redir_valid", bus.o_FetchUnit_valid, 32'd0);
      chk("hold_redir_req",   bus.o_FetchUnit_memReq, 32'd1);
      chk("hold_redir_addr",  bus.o_FetchUnit_memAddr, 32'h0000_5000);

      // Unaligned redirect arriving together with the ack.
      drive(1'b1, 32'h0000_6003, 1'b1, mem_word(32'h0000_5000), 1'b0);
      tick();
      chk("unaligned_addr",  bus.o_FetchUnit_memAddr, 32'h0000_6000);
      chk("unaligned_valid", bus.o_FetchUnit_valid, 32'd0);
      drive(1'b0, 32'd0, 1'b1, mem_word(32'h0000_6000), 1'b0);
      tick();
      chk("unaligned_deliver_pc", bus.o_FetchUnit_pc, 32'h0000_6000);
      chk("unaligned_deliver_v",  bus.o_FetchUnit_valid, 32'd1);

      // Reset mid-request, then a late ack is taken for the new request.
      drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      tick();
      chk("pre_rst_addr", bus.o_FetchUnit_memAddr, 32'h0000_6004);
      drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_memReq", bus.o_FetchUnit_memReq, 32'd0);
      chk("midrst_valid",  bus.o_FetchUnit_valid, 32'd0);
      tick();
      drive(1'b0, 32'd0, 1'b1, mem_word(RST_PC), 1'b0);
      rst_n = 1'b1;
      tick();
      chk("postrst_memReq", bus.o_FetchUnit_memReq, 32'd1);
      chk("postrst_addr",   bus.o_FetchUnit_memAddr, RST_PC);
      chk("postrst_valid",  bus.o_FetchUnit_valid, 32'd0);
      tick();
      chk("late_ack_valid", bus.o_FetchUnit_valid, 32'd1);
      chk("late_ack_pc",    bus.o_FetchUnit_pc, RST_PC);

      // Randomized traffic against the stream model.
      do_reset();
      prev_req = 0; prev_ack = 0; prev_valid = 0; prev_ready = 0; prev_redir = 0;
      prev_addr = 0; prev_pc = 0; prev_instr = 0; prev_tgt = 0;
      exp_next = RST_PC; req_addr = 0; taint = 0; wait_cnt = 0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (prev_redir) exp_next = prev_tgt & ~32'd3;
         if (prev_req && prev_redir) taint = 1'b1;
         if (prev_valid && prev_ready && !prev_redir) begin
            chk("rnd_deliver_pc",    prev_pc, exp_next);
            chk("rnd_deliver_instr", prev_instr, mem_word(prev_pc));
            chk("rnd_deliver_nextreq", bus.o_FetchUnit_memReq, 32'd1);
            exp_next = prev_pc + 32'd4;
         end
         if (prev_valid && !prev_ready && !prev_redir) begin
            chk("rnd_hold_valid", bus.o_FetchUnit_valid, 32'd1);
            chk("rnd_hold_pc",    bus.o_FetchUnit_pc, prev_pc);
            chk("rnd_hold_instr", bus.o_FetchUnit_instr, prev_instr);
         end
         if (prev_req && prev_ack) begin
            if (taint) begin
               chk("rnd_dropped_valid", bus.o_FetchUnit_valid, 32'd0);
               chk("rnd_dropped_req",   bus.o_FetchUnit_memReq, 32'd1);
            end else begin
               chk("rnd_ack_valid", bus.o_FetchUnit_valid, 32'd1);
               chk("rnd_ack_pc",    bus.o_FetchUnit_pc, req_addr);
               chk("rnd_ack_instr", bus.o_FetchUnit_instr, mem_word(req_addr));
               chk("rnd_ack_noreq", bus.o_FetchUnit_memReq, 32'd0);
            end
            taint = 1'b0;
         end else if (prev_req) begin
            chk("rnd_req_held", bus.o_FetchUnit_memReq, 32'd1);
            chk("rnd_addr_held", bus.o_FetchUnit_memAddr, prev_addr);
         end
         chk("rnd_req_valid_excl", 32'(bus.o_FetchUnit_memReq & bus.o_FetchUnit_valid), 32'd0);
         new_req = bus.o_FetchUnit_memReq && (!prev_req || prev_ack);
         if (new_req) begin
            chk("rnd_issue_addr", bus.o_FetchUnit_memAddr, exp_next);
            req_addr = bus.o_FetchUnit_memAddr;
            wait_cnt = int'($urandom_range(0, 3));
         end

         rd = ($urandom_range(0, 9) == 0);
         t  = $urandom;
         r  = 1'($urandom_range(0, 1));
         if (bus.o_FetchUnit_memReq) begin
            a = (wait_cnt == 0);
            if (wait_cnt > 0) wait_cnt--;
            d = mem_word(bus.o_FetchUnit_memAddr);
         end else begin
            a = ($urandom_range(0, 3) == 0);
            d = $urandom;
         end
         drive(rd, t, a, d, r);

         prev_req   = bus.o_FetchUnit_memReq;
         prev_addr  = bus.o_FetchUnit_memAddr;
         prev_valid = bus.o_FetchUnit_valid;
         prev_pc    = bus.o_FetchUnit_pc;
         prev_instr = bus.o_FetchUnit_instr;
         prev_ack   = a;
         prev_ready = r;
         prev_redir = rd;
         prev_tgt   = t;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
